// File: rtl/pkt_loss_injector.sv
// rtl/pkt_loss_injector.sv - packet-granular loss injector with LFSR drop decision and pass/drop counters
// Optional macro PKT_LOSS_NTH_EN adds io_drop_nth for deterministic every-Nth-packet dropping.
module pkt_loss_injector #(
    parameter int          DATA_W    = 512,
    parameter int          KEEP_W    = 64,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       io_drop_thresh,
`ifdef PKT_LOSS_NTH_EN
    input  logic [15:0]       io_drop_nth,
`endif
    input  logic              io_data_in_valid,
    output logic              io_data_in_ready,
    input  logic [DATA_W-1:0] io_data_in_bits_data,
    input  logic [KEEP_W-1:0] io_data_in_bits_keep,
    input  logic              io_data_in_bits_last,
    output logic              io_data_out_valid,
    input  logic              io_data_out_ready,
    output logic [DATA_W-1:0] io_data_out_bits_data,
    output logic [KEEP_W-1:0] io_data_out_bits_keep,
    output logic              io_data_out_bits_last,
    output logic [31:0]       io_pkt_pass_cnt,
    output logic [31:0]       io_pkt_drop_cnt
);
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_lfsr;
    logic [31:0]       w_lfsr_nxt;
    logic              w_rand_drop;
    logic              w_drop;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_first_fire;
    logic              w_fwd;
    logic              w_disc;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [KEEP_W-1:0] r_out_keep;
    logic              r_out_last;
    logic [31:0]       r_pass_cnt;
    logic [31:0]       r_drop_cnt;

    assign w_lfsr_nxt  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
    assign w_rand_drop = (io_drop_thresh == 16'hFFFF) | (r_lfsr[15:0] < io_drop_thresh);

`ifdef PKT_LOSS_NTH_EN
    logic [15:0] r_idx;
    logic [15:0] w_nth_m1;

    assign w_nth_m1 = io_drop_nth - 16'd1;
    assign w_drop   = (io_drop_nth != 16'd0) ? (r_idx == w_nth_m1) : w_rand_drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx <= 16'd0;
        end else if (w_first_fire) begin
            r_idx <= (r_idx == w_nth_m1) ? 16'd0 : r_idx + 16'd1;
        end
    end
`else
    assign w_drop = w_rand_drop;
`endif

    // A dropped packet's tail is swallowed even while the output register is stalled.
    assign w_in_ready   = (r_state == S_DROP) | ~r_out_valid | io_data_out_ready;
    assign w_in_fire    = io_data_in_valid & w_in_ready;
    assign w_out_fire   = r_out_valid & io_data_out_ready;
    assign w_first_fire = w_in_fire & (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_disc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (w_drop) begin
                        w_disc = 1'b1;
                        if (!io_data_in_bits_last) w_state_nxt = S_DROP;
                    end else begin
                        w_fwd = 1'b1;
                        if (!io_data_in_bits_last) w_state_nxt = S_PASS;
                    end
                end
            end
            S_PASS: begin
                w_fwd = w_in_fire;
                if (w_in_fire && io_data_in_bits_last) w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                w_disc = w_in_fire;
                if (w_in_fire && io_data_in_bits_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED_EFF;
        end else begin
            r_state <= w_state_nxt;
            if (w_first_fire) r_lfsr <= w_lfsr_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_fwd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= io_data_in_bits_data;
            r_out_keep  <= io_data_in_bits_keep;
            r_out_last  <= io_data_in_bits_last;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pass_cnt <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else begin
            if (w_fwd && io_data_in_bits_last)  r_pass_cnt <= r_pass_cnt + 32'd1;
            if (w_disc && io_data_in_bits_last) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign io_data_in_ready      = w_in_ready;
    assign io_data_out_valid     = r_out_valid;
    assign io_data_out_bits_data = r_out_data;
    assign io_data_out_bits_keep = r_out_keep;
    assign io_data_out_bits_last = r_out_last;
    assign io_pkt_pass_cnt       = r_pass_cnt;
    assign io_pkt_drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_pkt_loss_injector.sv
// tb/tb_pkt_loss_injector.sv - self-checking bench for pkt_loss_injector
`timescale 1ns/1ps
module tb_pkt_loss_injector;
    localparam int          DATA_W = 512;
    localparam int          KEEP_W = 64;
    localparam logic [31:0] SEED   = 32'hACE12468;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       thresh = 16'h0;
`ifdef PKT_LOSS_NTH_EN
    logic [15:0]       nth = 16'h0;
`endif
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEEP_W-1:0] in_keep = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              out_last;
    logic [31:0]       pass_cnt;
    logic [31:0]       drop_cnt;

    pkt_loss_injector #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LFSR_SEED(SEED)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_drop_thresh        (thresh),
`ifdef PKT_LOSS_NTH_EN
        .io_drop_nth           (nth),
`endif
        .io_data_in_valid      (in_valid),
        .io_data_in_ready      (in_ready),
        .io_data_in_bits_data  (in_data),
        .io_data_in_bits_keep  (in_keep),
        .io_data_in_bits_last  (in_last),
        .io_data_out_valid     (out_valid),
        .io_data_out_ready     (out_ready),
        .io_data_out_bits_data (out_data),
        .io_data_out_bits_keep (out_keep),
        .io_data_out_bits_last (out_last),
        .io_pkt_pass_cnt       (pass_cnt),
        .io_pkt_drop_cnt       (drop_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: packet-level view with a queue of beats owed downstream.
    typedef struct {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } beat_t;

    beat_t       expq[$];
    logic [31:0] m_lfsr;
    bit          m_mid;
    bit          m_cur_drop;
    int unsigned m_pass;
    int unsigned m_drop;
    int unsigned m_pkts;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic bit decide(input logic [15:0] th);
`ifdef PKT_LOSS_NTH_EN
        if (nth != 16'd0) return (m_pkts % nth) == (nth - 1);
`endif
        return (th == 16'hFFFF) || (m_lfsr[15:0] < th);
    endfunction

    task automatic model_reset();
        expq.delete();
        m_lfsr = SEED;
        m_mid = 0;
        m_cur_drop = 0;
        m_pass = 0;
        m_drop = 0;
        m_pkts = 0;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic run_cycle(input bit v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input bit l, input bit ordy, input logic [15:0] th, output bit fired);
        bit exp_rdy;
        in_valid = v; in_data = d; in_keep = k; in_last = l; out_ready = ordy; thresh = th;
        #2;
        exp_rdy = (m_mid && m_cur_drop) || (expq.size() == 0) || ordy;
        check1("in_ready", in_ready, exp_rdy);
        check1("out_valid", out_valid, expq.size() != 0);
        if (expq.size() != 0 && out_valid) begin
            checkd("out_data", out_data, expq[0].d);
            check32("out_keep_lo", out_keep[31:0], expq[0].k[31:0]);
            check32("out_keep_hi", out_keep[63:32], expq[0].k[63:32]);
            check1("out_last", out_last, expq[0].l);
        end
        fired = v && in_ready;
        if (ordy && expq.size() != 0) void'(expq.pop_front());
        if (fired) begin
            if (!m_mid) begin
                m_cur_drop = decide(th);
                m_lfsr = lfsr_next(m_lfsr);
                m_pkts++;
            end
            if (!m_cur_drop) expq.push_back('{d, k, l});
            if (l) begin
                if (m_cur_drop) m_drop++; else m_pass++;
                m_mid = 0;
            end else begin
                m_mid = 1;
            end
        end
        @(posedge clock);
        #1;
        check32("pass_cnt", pass_cnt, m_pass);
        check32("drop_cnt", drop_cnt, m_drop);
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d;
        bit          l;
        logic [15:0] th;
        bit          ov;
        logic [7:0]  od;
        bit          ol;
        logic [31:0] p;
        logic [31:0] dr;
    } vec_t;

    vec_t tbl[10];
    bit   dec1[10000];
    bit   dec2[10000];

    task automatic stat_run(output int unsigned drops, output int unsigned total, output bit dec[10000]);
        bit          fired;
        int unsigned n;
        logic [31:0] prev;
        apply_reset();
        n = 0;
        for (int c = 0; c < 12000 && n < 10000; c++) begin
            prev = drop_cnt;
            run_cycle(1'b1, DATA_W'(c), '1, 1'b1, 1'b1, 16'h8000, fired);
            if (fired) begin
                dec[n] = (drop_cnt != prev);
                n++;
            end
        end
        check32("stat_packets_sent", n, 32'd10000);
        drops = drop_cnt;
        total = pass_cnt + drop_cnt;
    endtask

    initial begin
        bit          fired;
        int          idx;
        int          len;
        int          pos;
        int unsigned drops1, total1, drops2, total2, diffs;
        logic [15:0] th;

        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #2;
        check1("rst_out_valid", out_valid, 1'b0);
        checkd("rst_out_data", out_data, '0);
        check32("rst_out_keep", out_keep[31:0], 32'h0);
        check1("rst_out_last", out_last, 1'b0);
        check32("rst_pass_cnt", pass_cnt, 32'h0);
        check32("rst_drop_cnt", drop_cnt, 32'h0);
        check1("rst_in_ready", in_ready, 1'b1);

        //          rst v  d  l  th        ov od ol  p  dr
        tbl[0] = '{1, 1, 1, 1, 16'h0000, 1, 1, 1, 1, 0};
        tbl[1] = '{0, 1, 2, 0, 16'h0000, 1, 2, 0, 1, 0};
        tbl[2] = '{0, 1, 3, 1, 16'h0000, 1, 3, 1, 2, 0};
        tbl[3] = '{0, 1, 4, 1, 16'h0000, 1, 4, 1, 3, 0};
        tbl[4] = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 3, 0};
        tbl[5] = '{1, 1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 1};
        tbl[6] = '{0, 1, 2, 0, 16'hFFFF, 0, 0, 0, 0, 1};
        tbl[7] = '{0, 1, 3, 1, 16'hFFFF, 0, 0, 0, 0, 2};
        tbl[8] = '{0, 1, 4, 1, 16'hFFFF, 0, 0, 0, 0, 3};
        tbl[9] = '{0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 3};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) apply_reset();
            in_valid = tbl[i].v; in_data = DATA_W'(tbl[i].d); in_keep = '1;
            in_last = tbl[i].l; thresh = tbl[i].th; out_ready = 1'b1;
            #2 check1("tbl_in_ready", in_ready, 1'b1);
            @(posedge clock);
            #1;
            check1("tbl_out_valid", out_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                checkd("tbl_out_data", out_data, DATA_W'(tbl[i].od));
                check1("tbl_out_last", out_last, tbl[i].ol);
            end
            check32("tbl_pass_cnt", pass_cnt, tbl[i].p);
            check32("tbl_drop_cnt", drop_cnt, tbl[i].dr);
        end

        // Backpressure: one beat parked in the output register, then drain.
        apply_reset();
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            run_cycle(idx < 4, DATA_W'(10 + idx), KEEP_W'(idx + 1), idx == 3, c >= 6, 16'h0000, fired);
            if (fired) idx++;
        end
        check32("bp_beats_accepted", idx, 32'd4);
        check32("bp_pass_cnt", pass_cnt, 32'd1);
        check1("bp_drained", out_valid, 1'b0);

        // Reset mid-packet: counters and output flushed, next beat decides with the seed LFSR.
        apply_reset();
        run_cycle(1'b1, DATA_W'(7), '1, 1'b1, 1'b1, 16'h0000, fired);
        run_cycle(1'b1, DATA_W'(1), '1, 1'b0, 1'b1, 16'h0000, fired);
        run_cycle(1'b1, DATA_W'(2), '1, 1'b0, 1'b1, 16'h0000, fired);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        check32("midrst_pass_cnt", pass_cnt, 32'd0);
        check32("midrst_drop_cnt", drop_cnt, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        run_cycle(1'b1, DATA_W'(3), '1, 1'b0, 1'b1, 16'h2469, fired);
        run_cycle(1'b1, DATA_W'(4), '1, 1'b1, 1'b1, 16'h0000, fired);
        check32("midrst_seed_drop", drop_cnt, 32'd1);
        check32("midrst_seed_pass", pass_cnt, 32'd0);

        // Randomised traffic with threshold churning every cycle.
        apply_reset();
        len = 1; pos = 0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       th = 16'h0000;
                1:       th = 16'hFFFF;
                default: th = 16'($urandom());
            endcase
            if (pos == 0) len = $urandom_range(1, 4);
            run_cycle(($urandom() % 4) != 0, {16{$urandom()}}, {$urandom(), $urandom()},
                      pos == len - 1, ($urandom() % 3) != 0, th, fired);
            if (fired) pos = (pos == len - 1) ? 0 : pos + 1;
        end

        // Statistical drop rate and run-to-run repeatability.
        stat_run(drops1, total1, dec1);
        check1("stat_drop_in_range", (drops1 >= 4800) && (drops1 <= 5200), 1'b1);
        check32("stat_total", total1, 32'd10000);
        stat_run(drops2, total2, dec2);
        diffs = 0;
        for (int i = 0; i < 10000; i++) if (dec1[i] != dec2[i]) diffs++;
        check32("stat_repeat_diffs", diffs, 32'd0);
        check32("stat_repeat_drops", drops2, drops1);

`ifdef PKT_LOSS_NTH_EN
        nth = 16'd3;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            run_cycle(1'b1, DATA_W'(i + 1), '1, 1'b1, 1'b1, 16'h0000, fired);
        end
        check32("nth_pass_cnt", pass_cnt, 32'd6);
        check32("nth_drop_cnt", drop_cnt, 32'd3);
        nth = 16'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pkt_loss_injector.md
Name: pkt_loss_injector

Overview:
- Packet-granular loss emulator placed directly upstream of the packet delay stage; its output stream feeds the delay stage's data_in.
- Decides once per packet, on the first beat, whether to forward or silently discard the whole packet, using a 32-bit LFSR compared against a programmable threshold.
- Adds one register stage on forwarded beats and exposes pass/drop packet counters for host readout.

Parameters:
DATA_W, 512, width of the data bus
KEEP_W, 64, width of the keep mask (DATA_W/8)
LFSR_SEED, 32'hACE12468, LFSR reset value; a value of 0 is replaced by 32'h1

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-high reset
io_drop_thresh  in  16  drop probability threshold; sampled at each packet's first beat
io_data_in_valid  in  1  upstream beat valid
io_data_in_ready  out  1  upstream beat ready
io_data_in_bits_data  in  DATA_W  beat data
io_data_in_bits_keep  in  KEEP_W  byte-valid mask
io_data_in_bits_last  in  1  final beat of packet
io_data_out_valid  out  1  beat valid toward delay stage
io_data_out_ready  in  1  delay stage ready
io_data_out_bits_data  out  DATA_W  forwarded data
io_data_out_bits_keep  out  KEEP_W  forwarded keep
io_data_out_bits_last  out  1  forwarded last
io_pkt_pass_cnt  out  32  packets forwarded; wraps at 2^32
io_pkt_drop_cnt  out  32  packets dropped; wraps at 2^32

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; lfsr=LFSR_SEED; counters=0.
  - io_data_out_valid=0; out data/keep/last=0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- LFSR:
  - 32-bit Galois, shift right, XOR mask 32'h80200003 when bit0=1.
  - Advances exactly once per first-beat in_fire; holds otherwise.
- Drop decision (combinational, first beat only):
  - drop = (io_drop_thresh==16'hFFFF) | (lfsr[15:0] < io_drop_thresh).
  - thresh=0 means never drop; thresh=16'hFFFF means always drop.
- FSM states IDLE / PASS / DROP:
  - IDLE, in_fire, drop=0: beat loaded to output register. Next state PASS if last=0; stay IDLE if last=1.
  - IDLE, in_fire, drop=1: beat discarded. Next state DROP if last=0; stay IDLE if last=1.
  - PASS: every in_fire beat is loaded to the output register. in_fire with last=1 -> IDLE.
  - DROP: every in_fire beat is discarded. in_fire with last=1 -> IDLE.
- Ready:
  - In IDLE and PASS, and in IDLE when the decision is drop: in_ready = !out_valid | out_ready.
  - In DROP: in_ready = 1, regardless of output state.
  - In IDLE, in_ready does not depend on in_valid.
- Output register (forwarded beats only):
  - Loaded on a forwarded in_fire; out_valid set.
  - Cleared on out_fire without a simultaneous load.
  - A simultaneous out_fire and load keeps out_valid=1 with the new beat, giving full throughput.
  - Latency: beat accepted in cycle N appears at the output in cycle N+1.
  - Output bits hold stable while out_valid=1 and out_ready=0.
- Counters:
  - pass_cnt += 1 on a forwarded beat with last=1.
  - drop_cnt += 1 on a discarded beat with last=1.
  - Both increment at the same cycle as the last-beat in_fire.
- Mid-packet threshold changes are ignored until the next packet's first beat.
- Reset asserted mid-packet: FSM returns to IDLE and the output register is flushed. The next accepted beat is treated as a first beat, even if it is a tail of the interrupted packet.
- keep is passed through unmodified; no packet-length checking.

Optional Feature:
- Macro: PKT_LOSS_NTH_EN.
- When defined:
  - Adds input io_drop_nth [15:0] and an internal 16-bit packet index counter, reset to 0.
  - The index increments on each first-beat in_fire and wraps to 0 when it reaches io_drop_nth-1.
  - If io_drop_nth != 0, drop = (index == io_drop_nth-1) and the LFSR comparison is bypassed; the LFSR still advances.
  - If io_drop_nth == 0, random mode applies.
- When undefined: no extra port and no index counter; random mode only.

Test Plan:
- thresh=0, out_ready=1: three packets (1 beat data=1; 2 beats data=2,3; 1 beat data=4) -> same 4 beats out, each 1 cycle after acceptance; pass_cnt=3, drop_cnt=0.
- thresh=16'hFFFF: the same three packets -> out_valid never asserts, in_ready=1 throughout; drop_cnt=3, pass_cnt=0.
- thresh=16'h8000, 10000 single-beat packets -> drop_cnt within 5000±200; pass_cnt+drop_cnt=10000; run twice with the same seed -> identical per-packet sequences.
- thresh=0, out_ready=0 for 5 cycles while a 4-beat packet is offered -> one beat held stable in the output register, in_ready=0; release -> all 4 beats out in order with no loss or duplication.
- Reset asserted after beat 2 of a 4-beat passing packet -> out_valid=0 and counters=0 immediately; the following beat counts as a first beat, and the LFSR restarts from LFSR_SEED.
- PKT_LOSS_NTH_EN, io_drop_nth=3, 9 single-beat packets -> packets 3, 6 and 9 dropped; pass_cnt=6, drop_cnt=3.
